// File: rtl/cache_pkg.sv
// Shared types and constants for the set-associative write-back cache.
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WRITE_BACK = 2'd1,
      REFILL     = 2'd2
   } state_t;

   localparam logic MEM_RD = 1'b1;
   localparam logic MEM_WR = 1'b0;

   localparam int ADDR_W    = 32;
   localparam int WORD_W    = 32;
   localparam int BYTE_BITS = 2;

   function automatic int tag_bits(input int set_bits, input int off_bits);
      return ADDR_W - BYTE_BITS - set_bits - off_bits;
   endfunction

endpackage

// File: rtl/set_asso_cache_wb_if.sv
// CPU load/store port and memory word port of the cache.
interface set_asso_cache_wb_if;
   import cache_pkg::*;

   logic              cpu_valid;
   logic              cpu_op;
   logic [ADDR_W-1:0] cpu_addr;
   logic [WORD_W-1:0] cpu_wdata;
   logic              cache_ready;
   logic [WORD_W-1:0] cache_rdata;
   logic              mem_valid;
   logic              mem_op;
   logic [ADDR_W-1:0] mem_addr;
   logic [WORD_W-1:0] mem_wdata;
   logic              mem_ready;
   logic [WORD_W-1:0] mem_rdata;

   modport slave (
      input  cpu_valid, cpu_op, cpu_addr, cpu_wdata,
      input  mem_ready, mem_rdata,
      output cache_ready, cache_rdata,
      output mem_valid, mem_op, mem_addr, mem_wdata
   );

   modport master (
      output cpu_valid, cpu_op, cpu_addr, cpu_wdata,
      output mem_ready, mem_rdata,
      input  cache_ready, cache_rdata,
      input  mem_valid, mem_op, mem_addr, mem_wdata
   );

endinterface

// File: rtl/cache_victim_sel.sv
// Victim way choice: lowest-index invalid way, else the round-robin pointer.
module cache_victim_sel #(
   parameter int WAY_NUM = 4,
   parameter int WAY_W   = $clog2(WAY_NUM)
) (
   input  logic [WAY_NUM-1:0] valid,
   input  logic [WAY_W-1:0]   rr_ptr,
   output logic [WAY_W-1:0]   way
);

   // Descending scan so the lowest invalid index is the last to win.
   always_comb begin
      way = rr_ptr;
      for (int i = WAY_NUM - 1; i >= 0; i--) begin
         if (!valid[i]) way = WAY_W'(i);
      end
   end

endmodule

// File: rtl/set_asso_cache_wb.sv
// N-way set-associative write-back, write-allocate cache with word bursts.
// Define CACHE_PERF_CNT_EN to add the hit/miss/write-back counters.
module set_asso_cache_wb
   import cache_pkg::*;
#(
   parameter int WAY_NUM    = 4,
   parameter int SET_BITS   = 4,
   parameter int LINE_WORDS = 4
) (
   input  logic               clk,
   input  logic               rst,
   set_asso_cache_wb_if.slave bus
`ifdef CACHE_PERF_CNT_EN
   ,
   output logic [31:0]        hit_cnt,
   output logic [31:0]        miss_cnt,
   output logic [31:0]        wb_cnt
`endif
);

   localparam int SETS     = 2 ** SET_BITS;
   localparam int OFF_BITS = $clog2(LINE_WORDS);
   localparam int TAG_BITS = tag_bits(SET_BITS, OFF_BITS);
   localparam int WAY_W    = $clog2(WAY_NUM);
   localparam int CNT_W    = (OFF_BITS > 0) ? OFF_BITS : 1;
   localparam int LINE_W   = TAG_BITS + SET_BITS;

   logic [WAY_NUM-1:0]  v_q    [SETS];
   logic [WAY_NUM-1:0]  d_q    [SETS];
   logic [WAY_W-1:0]    rr_q   [SETS];
   logic [TAG_BITS-1:0] tag_q  [SETS][WAY_NUM];
   logic [WORD_W-1:0]   data_q [SETS][WAY_NUM][LINE_WORDS];

   state_t              state_q;
   state_t              state_d;
   logic [CNT_W-1:0]    cnt_q;
   logic [WAY_W-1:0]    vic_q;
   logic [SET_BITS-1:0] ridx_q;
   logic [TAG_BITS-1:0] rtag_q;

   logic [SET_BITS-1:0] idx;
   logic [TAG_BITS-1:0] tag;
   logic [CNT_W-1:0]    off;
   logic                hit;
   logic [WAY_W-1:0]    hit_way;
   logic [WAY_W-1:0]    vic_way;
   logic                lookup;
   logic                ready;
   logic                miss;
   logic                wr_hit;
   logic                last;
   logic                xfer;
   logic                fill;
   logic [TAG_BITS-1:0] line_tag;
   logic [LINE_W-1:0]   line;

   assign idx = SET_BITS'(bus.cpu_addr >> (OFF_BITS + BYTE_BITS));
   assign tag = bus.cpu_addr[ADDR_W-1 -: TAG_BITS];
   assign off = (OFF_BITS == 0) ? '0 : CNT_W'(bus.cpu_addr >> BYTE_BITS);

   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = 0; w < WAY_NUM; w++) begin
         if (v_q[idx][w] && tag_q[idx][w] == tag) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
   end

   cache_victim_sel #(
      .WAY_NUM (WAY_NUM)
   ) u_victim_sel (
      .valid  (v_q[idx]),
      .rr_ptr (rr_q[idx]),
      .way    (vic_way)
   );

   assign lookup = (state_q == IDLE) && bus.cpu_valid;
   assign ready  = lookup && hit;
   assign miss   = lookup && !hit;
   assign wr_hit = ready && (bus.cpu_op == MEM_WR);
   assign last   = (cnt_q == CNT_W'(LINE_WORDS - 1));
   assign xfer   = bus.mem_valid && bus.mem_ready;
   assign fill   = (state_q == REFILL) && xfer;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (miss) begin
               if (v_q[idx][vic_way] && d_q[idx][vic_way])
                  state_d = WRITE_BACK;
               else
                  state_d = REFILL;
            end
         end
         WRITE_BACK: if (xfer && last) state_d = REFILL;
         REFILL:     if (xfer && last) state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   // Write-back uses the victim's stored tag, refill the requested one.
   assign line_tag = (state_q == WRITE_BACK) ? tag_q[ridx_q][vic_q] : rtag_q;
   assign line     = {line_tag, ridx_q};

   always_comb begin
      bus.cache_ready = ready;
      bus.cache_rdata = '0;
      if (ready && bus.cpu_op == MEM_RD)
         bus.cache_rdata = data_q[idx][hit_way][off];
      bus.mem_valid = (state_q != IDLE);
      bus.mem_op    = (state_q == REFILL) ? MEM_RD : MEM_WR;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (state_q != IDLE)
         bus.mem_addr = (ADDR_W'(line) << (OFF_BITS + BYTE_BITS))
                      | (ADDR_W'(cnt_q) << BYTE_BITS);
      if (state_q == WRITE_BACK)
         bus.mem_wdata = data_q[ridx_q][vic_q][cnt_q];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         vic_q  <= '0;
         ridx_q <= '0;
         rtag_q <= '0;
         for (int s = 0; s < SETS; s++) begin
            v_q[s]  <= '0;
            d_q[s]  <= '0;
            rr_q[s] <= '0;
         end
      end else begin
         if (miss) begin
            vic_q  <= vic_way;
            ridx_q <= idx;
            rtag_q <= tag;
         end
         if (xfer) cnt_q <= last ? '0 : cnt_q + 1'b1;
         if (wr_hit) d_q[idx][hit_way] <= 1'b1;
         if (fill && last) begin
            v_q[ridx_q][vic_q] <= 1'b1;
            d_q[ridx_q][vic_q] <= 1'b0;
            rr_q[ridx_q]       <= rr_q[ridx_q] + 1'b1;
         end
      end
   end

   // Tag and data storage carry no reset; V gates every use of them.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (wr_hit) data_q[idx][hit_way][off] <= bus.cpu_wdata;
         if (fill) begin
            data_q[ridx_q][vic_q][cnt_q] <= bus.mem_rdata;
            if (last) tag_q[ridx_q][vic_q] <= rtag_q;
         end
      end
   end

`ifdef CACHE_PERF_CNT_EN
   logic missed_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
         wb_cnt   <= '0;
         missed_q <= 1'b0;
      end else begin
         if (miss) miss_cnt <= miss_cnt + 1'b1;
         if (state_d == WRITE_BACK && state_q != WRITE_BACK)
            wb_cnt <= wb_cnt + 1'b1;
         if (ready) begin
            if (!missed_q) hit_cnt <= hit_cnt + 1'b1;
            missed_q <= 1'b0;
         end else if (miss) begin
            missed_q <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: doc/set_asso_cache_wb.md
Name: set_asso_cache_wb

Overview:
- Parametrised N-way set-associative cache. Write-back, write-allocate, multi-word lines.
- Sits between the CPU load/store port and main memory.
- Per-word valid/ready handshake on the memory side. Lines are refilled and written back as word bursts.
- Replacement: first invalid way, otherwise a per-set round-robin pointer.

Parameters:
- WAY_NUM, 4, ways per set (power of two, ≥2)
- SET_BITS, 4, index width; sets = 2**SET_BITS
- LINE_WORDS, 4, 32-bit words per line (power of two, ≥1)
- Derived: OFF_BITS=clog2(LINE_WORDS); TAG_BITS=30-SET_BITS-OFF_BITS

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- cpu_valid  in  1  request valid; held with op/addr/wdata stable until cache_ready
- cpu_op  in  1  1=read, 0=write
- cpu_addr  in  32  byte address; [1:0] ignored
- cpu_wdata  in  32  write data
- cache_ready  out  1  access complete this cycle
- cache_rdata  out  32  read data, valid with cache_ready on a read, else 0
- mem_valid  out  1  memory word request
- mem_op  out  1  1=read (refill), 0=write (write-back)
- mem_addr  out  32  word-aligned address
- mem_wdata  out  32  write-back data
- mem_ready  in  1  word transfer completes when mem_valid&&mem_ready
- mem_rdata  in  32  refill data, valid with mem_ready

Behaviour:
- Address fields: offset=addr[OFF_BITS+1:2], index=addr[OFF_BITS+SET_BITS+1:OFF_BITS+2], tag=addr[31:32-TAG_BITS].
- Per set/way state: V, D, tag, LINE_WORDS data. Per set: rr_ptr (clog2(WAY_NUM) bits).
- Hit = V && tag match in any way. Multiple matches cannot occur by construction.
- States: IDLE, WRITE_BACK, REFILL.
- IDLE, hit:
  - cache_ready=1 combinationally in the same cycle (0-cycle latency).
  - Read: cache_rdata = hit word.
  - Write: word updated and D set at clk edge.
- IDLE, miss with cpu_valid:
  - Victim is latched: lowest-index invalid way, else rr_ptr.
  - Victim V&&D → WRITE_BACK, else → REFILL.
- WRITE_BACK:
  - Issues LINE_WORDS writes at victim address {victim tag, index, word cnt, 2'b0}, cnt 0→LINE_WORDS-1.
  - Last accepted word → REFILL.
- REFILL:
  - Issues LINE_WORDS reads at {req tag, index, cnt, 2'b0}.
  - Each accepted word is written to the victim way.
  - On the last word: V=1, D=0, tag written, rr_ptr[index] += 1 (mod WAY_NUM), → IDLE.
- Back in IDLE the held request hits. Clean-miss latency = LINE_WORDS handshakes + 1 cycle.
- mem_valid/op/addr/wdata stay stable while mem_ready=0. Word counter wraps to 0 at the end of each burst.
- cache_ready=0 outside IDLE. No new lookup while busy.
- cpu_valid dropped mid-miss: the burst still completes, the line is installed, and no cache_ready is produced for it.
- Reset:
  - Clears all V, D, rr_ptr, state→IDLE, counters.
  - Data/tag arrays are not reset.
  - After reset, cache_ready=0 (no valid lines), mem_valid=0, cache_rdata=0.
  - Reset mid-burst abandons the burst. mem_valid=0 the cycle after rst is sampled.

Optional Feature:
- Macro: CACHE_PERF_CNT_EN.
- Defined: adds outputs hit_cnt, miss_cnt, wb_cnt, each 32 bits, wrapping, reset to 0.
  - miss_cnt +1 on each IDLE→miss exit.
  - wb_cnt +1 on each WRITE_BACK entry.
  - hit_cnt +1 on cache_ready only if the access did not miss (sticky per-request flag, cleared on cache_ready).
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package cache_pkg: state encodings (IDLE/WRITE_BACK/REFILL), MEM_RD/MEM_WR op constants, address-field width helper constants.
- Sub-module cache_victim_sel: inputs V vector and rr_ptr; outputs victim way index (priority on invalid, else pointer). Combinational, reused by future caches.

Test Plan (defaults; tag=addr[31:8], index=addr[7:4]):
1. Cold read 0x100, memory returns 0xA0..0xA3 → mem reads 0x100,0x104,0x108,0x10C. cache_ready with rdata 0xA0. Then read 0x108 → same-cycle ready, rdata 0xA2, mem_valid stays 0.
2. Write 0x104=0xDEAD (hit), then read misses 0x200, 0x300, 0x400 (ways 1–3), then read 0x500 → victim way0 (rr_ptr=0 after 4 refills). Write-back 0x100..0x10C data 0xA0, 0xDEAD, 0xA2, 0xA3. Then refill 0x500..0x50C.
3. Write miss 0x1014=0x55 → refill 0x1010..0x101C, then ready. Line is dirty. Read 0x1014 returns 0x55 with no memory traffic.
4. Hold mem_ready=0 for 5 cycles during refill word 2 → mem_valid/mem_addr 0x108 stable. No cache_ready until the burst ends.
5. Assert rst after 2 refill words → mem_valid=0 next cycle. Re-read 0x100 misses and re-issues a full 4-word refill.
6. With CACHE_PERF_CNT_EN, run scenario 1 → hit_cnt=1, miss_cnt=1, wb_cnt=0. Scenario 2 adds wb_cnt=1.
